// File: rtl/mem_ctrl_arbiter_if.sv
// Requester, RAM and control bundle for mem_ctrl_arbiter.
// slave = controller side, master = core/RAM side.
interface mem_ctrl_arbiter_if #(
  parameter int XLEN       = 32,
  parameter int ID_W       = 4,
  parameter int LINE_BYTES = 16
);
  localparam int IW = (LINE_BYTES > 4) ? $clog2(LINE_BYTES / 4) : 1;

  logic            rdy;
  logic            flush;
  logic            io_buffer_full;

  logic            ic_req;
  logic [XLEN-1:0] ic_addr;
  logic            ic_gnt;
  logic            ic_valid;
  logic [XLEN-1:0] ic_word;
  logic [IW-1:0]   ic_word_idx;
  logic            ic_done;

  logic            ld_req;
  logic [XLEN-1:0] ld_addr;
  logic [1:0]      ld_size;
  logic            ld_signed;
  logic [ID_W-1:0] ld_id;
  logic            ld_gnt;
  logic            ld_valid;
  logic [XLEN-1:0] ld_data;
  logic [ID_W-1:0] ld_id_out;

  logic            st_req;
  logic [XLEN-1:0] st_addr;
  logic [1:0]      st_size;
  logic [XLEN-1:0] st_data;
  logic            st_gnt;
  logic            st_done;

  logic [7:0]      ram_din;
  logic [7:0]      ram_dout;
  logic [XLEN-1:0] ram_a;
  logic            ram_wr;
  logic            busy;

  modport slave (
    input  rdy, flush, io_buffer_full,
    input  ic_req, ic_addr,
    output ic_gnt, ic_valid, ic_word, ic_word_idx, ic_done,
    input  ld_req, ld_addr, ld_size, ld_signed, ld_id,
    output ld_gnt, ld_valid, ld_data, ld_id_out,
    input  st_req, st_addr, st_size, st_data,
    output st_gnt, st_done,
    input  ram_din,
    output ram_dout, ram_a, ram_wr, busy
  );

  modport master (
    output rdy, flush, io_buffer_full,
    output ic_req, ic_addr,
    input  ic_gnt, ic_valid, ic_word, ic_word_idx, ic_done,
    output ld_req, ld_addr, ld_size, ld_signed, ld_id,
    input  ld_gnt, ld_valid, ld_data, ld_id_out,
    output st_req, st_addr, st_size, st_data,
    input  st_gnt, st_done,
    output ram_din,
    input  ram_dout, ram_a, ram_wr, busy
  );
endinterface

// File: rtl/mem_ctrl_arbiter.sv
// Byte-serial RAM controller/arbiter: store > load > icache refill.
// Ports: clk, rst (sync, active high), bus (mem_ctrl_arbiter_if.slave).
// Optional macro IO_FULL_STALL_EN: hold IO-range stores while UART full.
module mem_ctrl_arbiter #(
  parameter int XLEN       = 32,
  parameter int ID_W       = 4,
  parameter int LINE_BYTES = 16,
  parameter int RAM_LAT    = 1
) (
  input logic clk,
  input logic rst,
  mem_ctrl_arbiter_if.slave bus
);
  localparam int CW = $clog2(LINE_BYTES);
  localparam int IW = (LINE_BYTES > 4) ? $clog2(LINE_BYTES / 4) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  typedef enum logic [1:0] {K_ST, K_LD, K_IC} kind_t;

  state_t          state_q, state_d;
  kind_t           kind_q, kind_d;
  logic [XLEN-1:0] base_q, base_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [CW-1:0]   len_q, len_d;
  logic [CW-1:0]   iss_q, iss_d;
  logic [CW-1:0]   cap_q, cap_d;
  logic [RAM_LAT-1:0] pipe_q, pipe_d;
  logic            abort_q, abort_d;
  logic [1:0]      wait_q, wait_d;
  logic            sgn_q, sgn_d;
  logic [1:0]      sz_q, sz_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            icv_q, icv_d;
  logic [XLEN-1:0] icw_q, icw_d;
  logic [IW-1:0]   ici_q, ici_d;

  logic io_block, idle, st_g, ld_g, ic_g;
  logic is_rd, cap_en;
  logic [XLEN-1:0] ld_ext;

  function automatic logic [CW-1:0] sz_len(input logic [1:0] s);
    unique case (s)
      2'd0:    return CW'(0);
      2'd1:    return CW'(1);
      default: return CW'(3);
    endcase
  endfunction

`ifdef IO_FULL_STALL_EN
  assign io_block = bus.io_buffer_full &&
                    (bus.st_addr[17:16] == 2'b11);
`else
  logic unused_io_full;
  assign unused_io_full = bus.io_buffer_full;
  assign io_block = 1'b0;
`endif

  assign idle = (state_q == IDLE) && bus.rdy;
  assign st_g = idle && bus.st_req && !io_block;
  assign ld_g = idle && !bus.flush && bus.ld_req && !st_g;
  assign ic_g = idle && !bus.flush && bus.ic_req &&
                !st_g && !bus.ld_req;

  assign is_rd  = (kind_q != K_ST);
  // Read bytes leave the pipe RAM_LAT cycles after issue; an
  // aborted read drops them instead of capturing.
  assign cap_en = pipe_q[RAM_LAT-1] && is_rd &&
                  !abort_q && !bus.flush;

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    base_d  = base_q;
    data_d  = data_q;
    len_d   = len_q;
    iss_d   = iss_q;
    cap_d   = cap_q;
    abort_d = abort_q;
    wait_d  = wait_q;
    sgn_d   = sgn_q;
    sz_d    = sz_q;
    id_d    = id_q;
    icv_d   = 1'b0;
    icw_d   = icw_q;
    ici_d   = ici_q;
    pipe_d  = pipe_q << 1;
    pipe_d[0] = (state_q == ISSUE) && is_rd && !bus.flush;

    if (cap_en) begin
      data_d[{cap_q[1:0], 3'b000} +: 8] = bus.ram_din;
      cap_d = cap_q + CW'(1);
      if (kind_q == K_IC && cap_q[1:0] == 2'b11) begin
        icv_d = 1'b1;
        icw_d = XLEN'({bus.ram_din, data_q[23:0]});
        ici_d = IW'(cap_q >> 2);
      end
    end

    unique case (state_q)
      IDLE: begin
        if (st_g || ld_g || ic_g) begin
          state_d = ISSUE;
          iss_d   = '0;
          cap_d   = '0;
          pipe_d  = '0;
          abort_d = 1'b0;
          data_d  = '0;
          sgn_d   = bus.ld_signed;
          sz_d    = bus.ld_size;
          id_d    = bus.ld_id;
          unique case (1'b1)
            st_g: begin
              kind_d = K_ST;
              base_d = bus.st_addr;
              data_d = bus.st_data;
              len_d  = sz_len(bus.st_size);
            end
            ld_g: begin
              kind_d = K_LD;
              base_d = bus.ld_addr;
              len_d  = sz_len(bus.ld_size);
            end
            default: begin
              kind_d = K_IC;
              base_d = bus.ic_addr;
              len_d  = CW'(LINE_BYTES - 1);
            end
          endcase
        end
      end
      ISSUE: begin
        if (is_rd && bus.flush) begin
          state_d = DRAIN;
          abort_d = 1'b1;
          wait_d  = '0;
        end else if (iss_q == len_q) begin
          state_d = is_rd ? DRAIN : DONE;
        end else begin
          iss_d = iss_q + CW'(1);
        end
      end
      DRAIN: begin
        if (abort_q) begin
          wait_d = wait_q + 2'd1;
          if (wait_q == 2'(RAM_LAT - 1)) state_d = IDLE;
        end else if (bus.flush) begin
          abort_d = 1'b1;
          wait_d  = '0;
        end else if (cap_en && cap_q == len_q) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      kind_q  <= K_ST;
      base_q  <= '0;
      data_q  <= '0;
      len_q   <= '0;
      iss_q   <= '0;
      cap_q   <= '0;
      pipe_q  <= '0;
      abort_q <= 1'b0;
      wait_q  <= '0;
      sgn_q   <= 1'b0;
      sz_q    <= '0;
      id_q    <= '0;
      icv_q   <= 1'b0;
      icw_q   <= '0;
      ici_q   <= '0;
    end else if (bus.rdy) begin
      state_q <= state_d;
      kind_q  <= kind_d;
      base_q  <= base_d;
      data_q  <= data_d;
      len_q   <= len_d;
      iss_q   <= iss_d;
      cap_q   <= cap_d;
      pipe_q  <= pipe_d;
      abort_q <= abort_d;
      wait_q  <= wait_d;
      sgn_q   <= sgn_d;
      sz_q    <= sz_d;
      id_q    <= id_d;
      icv_q   <= icv_d;
      icw_q   <= icw_d;
      ici_q   <= ici_d;
    end
  end

  always_comb begin
    ld_ext = data_q;
    unique case (sz_q)
      2'd0:
        ld_ext = {{(XLEN-8){sgn_q & data_q[7]}}, data_q[7:0]};
      2'd1:
        ld_ext = {{(XLEN-16){sgn_q & data_q[15]}}, data_q[15:0]};
      default: ld_ext = data_q;
    endcase
  end

  assign bus.st_gnt   = st_g;
  assign bus.ld_gnt   = ld_g;
  assign bus.ic_gnt   = ic_g;
  assign bus.busy     = (state_q != IDLE);
  assign bus.ld_valid = bus.rdy && state_q == DONE &&
                        kind_q == K_LD && !bus.flush;
  assign bus.st_done  = bus.rdy && state_q == DONE &&
                        kind_q == K_ST;
  assign bus.ld_data   = bus.ld_valid ? ld_ext : '0;
  assign bus.ld_id_out = bus.ld_valid ? id_q : '0;
  assign bus.ic_valid  = bus.rdy && icv_q && !bus.flush;
  assign bus.ic_done   = bus.ic_valid && state_q == DONE;
  assign bus.ic_word     = icw_q;
  assign bus.ic_word_idx = ici_q;
  assign bus.ram_a  = (state_q == ISSUE) ?
                      base_q + XLEN'(iss_q) : '0;
  // Gated by rdy so a frozen cycle never repeats a write.
  assign bus.ram_wr = bus.rdy && state_q == ISSUE &&
                      kind_q == K_ST;
  assign bus.ram_dout = bus.ram_wr ?
                        data_q[{iss_q[1:0], 3'b000} +: 8] : 8'h00;
endmodule

// File: doc/mem_ctrl_arbiter.md
Name: mem_ctrl_arbiter

Overview:
- Byte-serial RAM controller and arbiter for the out-of-order core.
- Three requesters share the single 8-bit RAM port: ROB store commit, LSB load, and icache line refill.
- Fully registered FSM with a req/grant handshake, parametrised line size and RAM read latency.
- Sign/zero extension of loads is done here; flush aborts speculative traffic but never a committed store.

Parameters:
- XLEN, 32, data/address width.
- ID_W, 4, ROB tag width.
- LINE_BYTES, 16, icache refill size in bytes; power of two, 4..64.
- RAM_LAT, 1, cycles from address driven to ram_din valid; 1..3.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- rdy  in  1  global enable; low freezes all state.
- flush  in  1  misprediction flush.
- ic_req  in  1  refill request, held until ic_gnt.
- ic_addr  in  XLEN  line-aligned refill address.
- ic_gnt  out  1  one-cycle grant.
- ic_valid  out  1  one cycle per refilled word.
- ic_word  out  XLEN  refilled word.
- ic_word_idx  out  log2(LINE_BYTES/4)  word index within line.
- ic_done  out  1  last word of line.
- ld_req  in  1  load request, held until ld_gnt.
- ld_addr  in  XLEN  load address.
- ld_size  in  2  0 = byte, 1 = half, 2 = word.
- ld_signed  in  1  sign-extend result.
- ld_id  in  ID_W  ROB tag.
- ld_gnt  out  1  grant.
- ld_valid  out  1  result pulse.
- ld_data  out  XLEN  result.
- ld_id_out  out  ID_W  tag of result.
- st_req  in  1  store request, held until st_gnt.
- st_addr  in  XLEN  store address.
- st_size  in  2  as ld_size.
- st_data  in  XLEN  store data.
- st_gnt  out  1  grant.
- st_done  out  1  store complete pulse.
- io_buffer_full  in  1  UART buffer full.
- ram_din  in  8  RAM read byte.
- ram_dout  out  8  RAM write byte.
- ram_a  out  XLEN  RAM byte address.
- ram_wr  out  1  write strobe.
- busy  out  1  transaction in flight.

Behaviour:
- Reset (sync, rst=1 at posedge): FSM=IDLE; every output 0; byte counter 0. Reset mid-transaction abandons it, including a store.
- rdy=0: no state update at posedge. ram_wr is held 0 combinationally so no write is repeated.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: grant is decided combinationally from request lines.
  - Priority: st > ld > ic.
  - Grant pulses in the same cycle G. Operands are latched at the G posedge; go to ISSUE.
  - With flush=1, ld_req and ic_req are ignored; st_req may still be granted.
- Transaction length n:
  - store/load: 1, 2 or 4 bytes per size.
  - refill: LINE_BYTES.
  - ld_size/st_size = 3 is treated as word.
- ISSUE: byte i is driven on ram_a = base+i in cycle G+1+i, i = 0..n-1. Address arithmetic wraps modulo 2^XLEN.
- Stores drive ram_wr=1 and ram_dout = st_data[8i+7:8i] on those cycles; ram_wr=0 in all other cycles.
- Read capture: byte i is captured from ram_din at the end of cycle G+1+i+RAM_LAT, little-endian.
- DRAIN: waits for outstanding read bytes. Stores skip DRAIN.
- DONE, one cycle, then back to IDLE:
  - Load DONE is cycle G+n+RAM_LAT+1. ld_valid=1; ld_data is extended from bit 8n-1 (sign if ld_signed, else zero).
  - Store DONE is cycle G+n+1. st_done=1.
  - Refill: ic_valid pulses in the cycle after each 4th byte is captured. ic_word_idx counts 0..LINE_BYTES/4-1; ic_done accompanies the last ic_valid, which is in DONE.
- A new grant may occur in the cycle after DONE.
- busy: 1 from cycle G+1 through DONE inclusive; 0 in IDLE.
- flush during a load or refill:
  - Stop issuing; no ld_valid/ic_valid/ic_done for that transaction.
  - Discard in-flight bytes, waiting RAM_LAT cycles, then return to IDLE.
- flush during a store: ignored; the store completes.
- flush coinciding with DONE of a load suppresses ld_valid.
- Unaligned addresses: legal; bytes are sequential.

Optional Feature:
- IO_FULL_STALL_EN.
- Defined: a store with st_addr[17:16]==2'b11 (0x30000 IO range) is not granted while io_buffer_full=1. Lower-priority load/refill requests may be granted instead in that cycle.
- Undefined: io_buffer_full is ignored; IO stores are granted like any store.

Test Plan:
- Reset 3 cycles, then idle: all outputs 0; RAM_LAT=1, ld word @0x100 signed, RAM bytes 0x78,0x56,0x34,0x92 -> ld_gnt at G, ram_a 0x100..0x103 at G+1..G+4, ld_valid at G+6, ld_data=0x92345678, ld_id_out echoes ld_id.
- LB signed @0x7 byte 0x80 -> ld_data=0xFFFFFF80; same with ld_signed=0 -> 0x00000080; LH @0xFFFFFFFF -> second address wraps to 0x0.
- st_req, ld_req, ic_req all asserted together -> st_gnt first; SW 0xDEADBEEF @0x200 writes EF,BE,AD,DE on 0x200..0x203 with ram_wr=1; st_done G+5; then ld_gnt, then ic_gnt.
- Refill LINE_BYTES=16 @0x40 -> ic_valid×4 with idx 0..3, words assembled correctly, ic_done with idx 3; flush at byte 6 -> no further ic_valid, busy drops after RAM_LAT cycles, no ic_done.
- flush mid-store SB -> write still performed, st_done pulses; rdy low 5 cycles mid-load -> ram_a frozen, result identical to uninterrupted run.
- IO_FULL_STALL_EN defined, io_buffer_full=1, SB @0x30000 -> no st_gnt; pending ld_req granted; deassert full -> store granted next IDLE cycle.
